// File: rtl/ball_engine_if.sv
// Ball engine port bundle: game-speed tick, serve request, paddle positions
// in; ball position, scores and rally status out.
interface ball_engine_if #(
   parameter int BIT_OF_WIDTH = 3
);
   logic                    tick;
   logic                    start;
   logic [BIT_OF_WIDTH-1:0] player_top;
   logic [BIT_OF_WIDTH-1:0] player_down;
   logic [BIT_OF_WIDTH-1:0] x_pos;
   logic [BIT_OF_WIDTH-1:0] y_pos;
   logic [3:0]              score_top;
   logic [3:0]              score_down;
   logic                    point;
   logic                    game_over;

   modport master (
      output tick, start, player_top, player_down,
      input  x_pos, y_pos, score_top, score_down, point, game_over
   );

   modport slave (
      input  tick, start, player_top, player_down,
      output x_pos, y_pos, score_top, score_down, point, game_over
   );
endinterface

// File: rtl/ball_engine.sv
// Ball and rally controller for the LED pong matrix: moves the ball once per
// tick, bounces it off walls and paddles, detects misses, keeps scores and
// sequences serve / point hold / game over.
module ball_engine #(
   parameter int WIDTH        = 8,
   parameter int BIT_OF_WIDTH = 3,
   parameter int SIZE         = 2,
   parameter int MAX_SCORE    = 7,
   parameter int HOLD_TICKS   = 2
) (
   input  logic          clk,
   input  logic          rst,
   ball_engine_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;

   localparam int CW  = BIT_OF_WIDTH + 1;
   localparam int HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   localparam logic [BIT_OF_WIDTH-1:0] CENTER = BIT_OF_WIDTH'(WIDTH/2 - 1);
   localparam logic [BIT_OF_WIDTH-1:0] MAXC   = BIT_OF_WIDTH'(WIDTH - 1);
   localparam logic [BIT_OF_WIDTH-1:0] ONE    = BIT_OF_WIDTH'(1);
   localparam logic [BIT_OF_WIDTH-1:0] TWO    = BIT_OF_WIDTH'(2);
   localparam logic [BIT_OF_WIDTH-1:0] ZERO   = '0;
   localparam logic [3:0]              MAXS   = 4'(MAX_SCORE);
   localparam logic [HCW-1:0]          HLAST  = HCW'(HOLD_TICKS - 1);

   state_t                  state, state_nx;
   logic [BIT_OF_WIDTH-1:0] x, x_nx, y, y_nx;
   logic                    dir_x, dir_x_nx;   // 1 = +1 (right)
   logic                    dir_y, dir_y_nx;   // 1 = +1 (down)
   logic [3:0]              sc_top, sc_top_nx, sc_down, sc_down_nx;
   logic                    point, point_nx;
   logic                    over, over_nx;
   logic [HCW-1:0]          hold, hold_nx;

   // Paddle coverage of the current column, widened by one bit so the
   // paddle extent never wraps.
   logic [CW-1:0] cx, idx_top, pt, pd;
   logic          cov_top, cov_down, in_field;

   always_comb begin
      cx       = CW'(x);
      idx_top  = CW'(WIDTH - 1) - cx;
      pt       = CW'(bus.player_top);
      pd       = CW'(bus.player_down);
      in_field = (cx >= CW'(1)) && (cx <= CW'(WIDTH - 2));
      cov_down = in_field && (cx >= pd) && (cx <= pd + CW'(SIZE));
      cov_top  = in_field && (idx_top >= pt) && (idx_top <= pt + CW'(SIZE));
   end

   // Next-state and datapath: one ball step per tick in PLAY, hold timer in SCORED.
   always_comb begin
      state_nx   = state;
      x_nx       = x;
      y_nx       = y;
      dir_x_nx   = dir_x;
      dir_y_nx   = dir_y;
      sc_top_nx  = sc_top;
      sc_down_nx = sc_down;
      hold_nx    = hold;
      point_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nx = PLAY;
         end
         PLAY: begin
            if (bus.tick) begin
               if (dir_x && x == MAXC) begin
                  dir_x_nx = 1'b0;
                  x_nx     = MAXC - ONE;
               end else if (!dir_x && x == ZERO) begin
                  dir_x_nx = 1'b1;
                  x_nx     = ONE;
               end else begin
                  x_nx = dir_x ? x + ONE : x - ONE;
               end

               if (!dir_y && y == ONE) begin
                  if (cov_top) begin
                     dir_y_nx = 1'b1;
                     y_nx     = TWO;
                  end else begin
                     y_nx       = ZERO;
                     point_nx   = 1'b1;
                     sc_down_nx = (sc_down < MAXS) ? sc_down + 4'd1 : sc_down;
                     state_nx   = SCORED;
                     hold_nx    = '0;
                  end
               end else if (dir_y && y == MAXC - ONE) begin
                  if (cov_down) begin
                     dir_y_nx = 1'b0;
                     y_nx     = MAXC - TWO;
                  end else begin
                     y_nx      = MAXC;
                     point_nx  = 1'b1;
                     sc_top_nx = (sc_top < MAXS) ? sc_top + 4'd1 : sc_top;
                     state_nx  = SCORED;
                     hold_nx   = '0;
                  end
               end else begin
                  y_nx = dir_y ? y + ONE : y - ONE;
               end
            end
         end
         SCORED: begin
            if (bus.tick) begin
               if (hold == HLAST) begin
                  state_nx = (sc_top == MAXS || sc_down == MAXS) ? OVER : IDLE;
                  x_nx     = CENTER;
                  y_nx     = CENTER;
                  dir_x_nx = 1'b1;
                  // Serve toward the player who just conceded.
                  dir_y_nx = (y == MAXC);
                  hold_nx  = '0;
               end else begin
                  hold_nx = hold + HCW'(1);
               end
            end
         end
         default: ;  // OVER: everything frozen until reset
      endcase
      over_nx = (state_nx == OVER);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         x       <= CENTER;
         y       <= CENTER;
         dir_x   <= 1'b1;
         dir_y   <= 1'b1;
         sc_top  <= '0;
         sc_down <= '0;
         hold    <= '0;
         point   <= 1'b0;
         over    <= 1'b0;
      end else begin
         state   <= state_nx;
         x       <= x_nx;
         y       <= y_nx;
         dir_x   <= dir_x_nx;
         dir_y   <= dir_y_nx;
         sc_top  <= sc_top_nx;
         sc_down <= sc_down_nx;
         hold    <= hold_nx;
         point   <= point_nx;
         over    <= over_nx;
      end
   end

   assign bus.x_pos      = x;
   assign bus.y_pos      = y;
   assign bus.score_top  = sc_top;
   assign bus.score_down = sc_down;
   assign bus.point      = point;
   assign bus.game_over  = over;
endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: rally steps, paddle bounces, misses,
// hold/serve, game over and mid-hold reset, with hand-computed positions.
module tb_ball_engine;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ball_engine_if bus ();

   ball_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int ex, input int ey);
      chk({tag, ".x"}, int'(bus.x_pos), ex);
      chk({tag, ".y"}, int'(bus.y_pos), ey);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   // Serve from centre with the bottom paddle away: (4,4)(5,5)(6,6)(7,7) miss.
   task automatic rally_miss();
      do_start();
      for (int k = 0; k < 4; k++) do_tick();
   endtask

   initial begin
      rst             = 1'b1;
      bus.tick        = 1'b0;
      bus.start       = 1'b0;
      bus.player_top  = 3'd0;
      bus.player_down = 3'd0;
      cyc();
      cyc();
      rst = 1'b0;

      // Reset state
      chk_pos("reset", 3, 3);
      chk("reset.score_top", int'(bus.score_top), 0);
      chk("reset.score_down", int'(bus.score_down), 0);
      chk("reset.point", int'(bus.point), 0);
      chk("reset.game_over", int'(bus.game_over), 0);

      // Tick in IDLE does nothing; start takes no step
      do_tick();
      chk_pos("idle_tick", 3, 3);
      do_start();
      chk_pos("start", 3, 3);

      // Diagonal steps down-right
      do_tick(); chk_pos("step1", 4, 4);
      do_tick(); chk_pos("step2", 5, 5);
      do_tick(); chk_pos("step3", 6, 6);
      chk("step3.point", int'(bus.point), 0);

      // Bottom paddle covers 4..6: bounce up, then right-wall bounce
      bus.player_down = 3'd4;
      do_tick(); chk_pos("bot_hit", 7, 5);
      do_tick(); chk_pos("wall_x", 6, 4);

      // Moving up-left; top paddle at 7 covers nothing in-field -> top miss
      bus.player_top = 3'd7;
      do_tick(); chk_pos("up1", 5, 3);
      do_tick(); chk_pos("up2", 4, 2);
      do_tick(); chk_pos("up3", 3, 1);
      do_tick(); chk_pos("top_miss", 2, 0);
      chk("top_miss.point", int'(bus.point), 1);
      chk("top_miss.score_down", int'(bus.score_down), 1);
      chk("top_miss.score_top", int'(bus.score_top), 0);
      cyc();
      chk("top_miss.point_drop", int'(bus.point), 0);
      do_tick(); chk_pos("hold1", 2, 0);
      do_tick(); chk_pos("hold_done", 3, 3);
      do_tick(); chk_pos("back_idle", 3, 3);

      // Serve upward (top conceded); top paddle 1 covers columns 6..4
      do_start();
      do_tick(); chk_pos("serve_up1", 4, 2);
      do_tick(); chk_pos("serve_up2", 5, 1);
      bus.player_top = 3'd1;
      do_tick(); chk_pos("top_hit", 6, 2);
      do_tick(); chk_pos("after_top_hit", 7, 3);

      // start and tick in the same IDLE cycle: no step
      do_reset();
      bus.player_down = 3'd0;
      bus.start = 1'b1;
      bus.tick  = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.tick  = 1'b0;
      chk_pos("start_tick", 3, 3);

      // Bottom miss: paddle 0 covers only 1..2
      do_tick(); do_tick(); do_tick();
      chk_pos("pre_miss", 6, 6);
      do_tick(); chk_pos("bot_miss", 7, 7);
      chk("bot_miss.point", int'(bus.point), 1);
      chk("bot_miss.score_top", int'(bus.score_top), 1);
      chk("bot_miss.score_down", int'(bus.score_down), 0);
      do_tick();
      chk("bot_miss.point_once", int'(bus.point), 0);
      chk_pos("bot_hold1", 7, 7);
      do_tick(); chk_pos("bot_hold_done", 3, 3);
      chk("bot_hold_done.game_over", int'(bus.game_over), 0);
      do_tick(); chk_pos("bot_idle", 3, 3);
      do_start();
      do_tick(); chk_pos("serve_down", 4, 4);

      // Reset during the hold with score_top = 3
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         rally_miss();
         chk("rst_seq.score_top", int'(bus.score_top), i);
         if (i < 3) begin
            do_tick();
            do_tick();
         end
      end
      do_tick();
      do_reset();
      chk_pos("mid_hold_rst", 3, 3);
      chk("mid_hold_rst.score_top", int'(bus.score_top), 0);
      chk("mid_hold_rst.score_down", int'(bus.score_down), 0);
      chk("mid_hold_rst.point", int'(bus.point), 0);
      chk("mid_hold_rst.game_over", int'(bus.game_over), 0);

      // Seven bottom misses end the game
      for (int i = 1; i <= 7; i++) begin
         rally_miss();
         chk("game.score_top", int'(bus.score_top), i);
         do_tick();
         chk("game.over_during_hold", int'(bus.game_over), 0);
         do_tick();
      end
      chk("over.game_over", int'(bus.game_over), 1);
      chk_pos("over", 3, 3);
      do_start();
      do_tick();
      do_tick();
      chk_pos("over_frozen", 3, 3);
      chk("over_frozen.game_over", int'(bus.game_over), 1);
      chk("over_frozen.score_top", int'(bus.score_top), 7);
      chk("over_frozen.score_down", int'(bus.score_down), 0);
      chk("over_frozen.point", int'(bus.point), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
